// File: rtl/memory_tx_sequencer.sv
// Drains a block of words from the buffer read port and streams them MSB-byte-first over valid/ready.
// Latency: start edge to first valid = 3 edges; 2-cycle bubble between words. Holds byte while !ready.
// Optional trailing XOR checksum byte when MEM_TX_CHECKSUM_EN is defined.
module memory_tx_sequencer #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    input  logic                     start_in,
    input  logic [ADDRESS_WIDTH-1:0] start_address_in,
    input  logic [ADDRESS_WIDTH:0]   word_count_in,
    output logic [ADDRESS_WIDTH-1:0] read_address_out,
    input  logic [DATA_WIDTH-1:0]    memory_data_in,
    output logic [7:0]               tx_data_out,
    output logic                     tx_valid_out,
    input  logic                     tx_ready_in,
    output logic                     busy_out,
    output logic                     done_out
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_SEND,
        S_CHECK
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   word_reg;
    logic [IW-1:0]           byte_idx;
    logic [ADDRESS_WIDTH:0]  remaining;
`ifdef MEM_TX_CHECKSUM_EN
    logic [7:0]              checksum;
`endif

    logic handshake;
    logic last_byte;
    logic last_word;

    assign handshake = tx_valid_out & tx_ready_in;
    assign last_byte = (byte_idx == IW'(BPW - 1));
    assign last_word = (remaining == {{ADDRESS_WIDTH{1'b0}}, 1'b1});
    assign busy_out  = (state != S_IDLE);

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state            <= S_IDLE;
            read_address_out <= '0;
            tx_data_out      <= 8'h00;
            tx_valid_out     <= 1'b0;
            done_out         <= 1'b0;
            word_reg         <= '0;
            byte_idx         <= '0;
            remaining        <= '0;
`ifdef MEM_TX_CHECKSUM_EN
            checksum         <= 8'h00;
`endif
        end else begin
            done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        read_address_out <= start_address_in;
                        remaining        <= word_count_in;
`ifdef MEM_TX_CHECKSUM_EN
                        checksum         <= 8'h00;
`endif
                        if (word_count_in != '0) begin
                            state <= S_FETCH;
                        end else begin
`ifdef MEM_TX_CHECKSUM_EN
                            // Empty block still emits a zero checksum byte.
                            tx_data_out  <= 8'h00;
                            tx_valid_out <= 1'b1;
                            state        <= S_CHECK;
`else
                            done_out     <= 1'b1;
`endif
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    word_reg     <= memory_data_in;
                    tx_data_out  <= memory_data_in[DATA_WIDTH-1 -: 8];
                    tx_valid_out <= 1'b1;
                    byte_idx     <= '0;
                    state        <= S_SEND;
                end
                S_SEND: begin
                    if (handshake) begin
`ifdef MEM_TX_CHECKSUM_EN
                        checksum <= checksum ^ tx_data_out;
`endif
                        if (!last_byte) begin
                            byte_idx    <= byte_idx + 1'b1;
                            tx_data_out <= word_reg[(DATA_WIDTH - 9) - 8 * int'(byte_idx) -: 8];
                        end else if (!last_word) begin
                            tx_valid_out     <= 1'b0;
                            read_address_out <= read_address_out + 1'b1;
                            remaining        <= remaining - 1'b1;
                            state            <= S_FETCH;
                        end else begin
`ifdef MEM_TX_CHECKSUM_EN
                            // Fold in the byte being transferred now; checksum reg lags by one.
                            tx_data_out <= checksum ^ tx_data_out;
                            state       <= S_CHECK;
`else
                            tx_valid_out <= 1'b0;
                            done_out     <= 1'b1;
                            state        <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef MEM_TX_CHECKSUM_EN
                S_CHECK: begin
                    if (handshake) begin
                        tx_valid_out <= 1'b0;
                        done_out     <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
`endif
                default: begin
                    tx_valid_out <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_tx_sequencer.sv
// Bench for memory_tx_sequencer: directed scenarios plus randomized blocks against a byte-stream model.
module tb_memory_tx_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  start_addr;
    logic [5:0]  word_count;
    logic [4:0]  read_address;
    logic [15:0] mem_rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int rmode  = 2;

    logic [15:0] mem [32];
    byte unsigned obs[$];
    byte unsigned exp_q[$];
    logic [4:0]   addr_q[$];

    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;
    logic       pdone = 1'b0;

    memory_tx_sequencer #(.DATA_WIDTH(16), .ADDRESS_WIDTH(5)) dut (
        .clock_in         (clk),
        .reset_n_in       (rst_n),
        .start_in         (start),
        .start_address_in (start_addr),
        .word_count_in    (word_count),
        .read_address_out (read_address),
        .memory_data_in   (mem_rd),
        .tx_data_out      (tx_data),
        .tx_valid_out     (tx_valid),
        .tx_ready_in      (tx_ready),
        .busy_out         (busy),
        .done_out         (done)
    );

    always #5 clk = ~clk;

    // Buffer read port: registered, one cycle latency.
    always @(posedge clk) mem_rd <= mem[read_address];

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0; pr = 1'b0; pdone = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("stall_valid_held", {31'b0, tx_valid}, 32'd1);
                check("stall_data_held", {24'b0, tx_data}, {24'b0, pd});
            end
            if (tx_valid && tx_ready) obs.push_back(tx_data);
            if (pdone) check("done_single_cycle", {31'b0, done}, 32'd0);
            if (!busy) check("no_valid_in_idle", {31'b0, tx_valid}, 32'd0);
            if (busy && (addr_q.size() == 0 || addr_q[$] != read_address))
                addr_q.push_back(read_address);
            pv = tx_valid; pr = tx_ready; pd = tx_data; pdone = done;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0) tx_ready = 1'b1;
            else if (rmode == 1) tx_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic void build_exp(input int addr, input int count);
        byte unsigned cs = 8'h00;
        exp_q.delete();
        for (int w = 0; w < count; w++) begin
            logic [15:0] word = mem[(addr + w) % 32];
            for (int b = 0; b < 2; b++) begin
                byte unsigned by = 8'((word >> (8 * (1 - b))) & 16'h00FF);
                exp_q.push_back(by);
                cs = cs ^ by;
            end
        end
`ifdef MEM_TX_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endfunction

    task automatic do_start(input int addr, input int count);
        @(posedge clk); #1;
        start = 1'b1; start_addr = 5'(addr); word_count = 6'(count);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        check(tag, {31'b0, got}, 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        int n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        check({tag, "_len"}, obs.size(), exp_q.size());
        for (int i = 0; i < n; i++) check({tag, "_byte"}, {24'b0, obs[i]}, {24'b0, exp_q[i]});
    endtask

    task automatic run_and_check(input int addr, input int count, input string tag);
        build_exp(addr, count);
        obs.delete();
        do_start(addr, count);
        wait_done({tag, "_done"});
        @(negedge clk);
        compare_stream(tag);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; word_count = '0; tx_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        #12;
        check("rst_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_addr", {27'b0, read_address}, 32'd0);
        check("rst_data", {24'b0, tx_data}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single word, ready always high, with latency probe.
        mem[3] = 16'hA55A;
        rmode = 0;
        build_exp(3, 1);
        obs.delete();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 5'd3; word_count = 6'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("lat_edge1_valid", {31'b0, tx_valid}, 32'd0);
        check("lat_edge1_busy", {31'b0, busy}, 32'd1);
        check("lat_edge1_addr", {27'b0, read_address}, 32'd3);
        @(posedge clk); #1;
        check("lat_edge2_valid", {31'b0, tx_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge3_valid", {31'b0, tx_valid}, 32'd1);
        check("lat_edge3_data", {24'b0, tx_data}, 32'hA5);
        @(posedge clk); #1;
        check("second_byte", {24'b0, tx_data}, 32'h5A);
        wait_done("t2_done");
        check("t2_busy_at_done", {31'b0, busy}, 32'd0);
        @(negedge clk);
        compare_stream("t2");

        // Wrap-around block with a 5-cycle stall on byte 0x34.
        mem[30] = 16'h1234; mem[31] = 16'h5678; mem[0] = 16'h9ABC;
        rmode = 2; tx_ready = 1'b1;
        build_exp(30, 3);
        obs.delete(); addr_q.delete();
        do_start(30, 3);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (tx_valid && tx_data == 8'h34) begin found = 1'b1; break; end
        end
        check("t4_saw_34", {31'b0, found}, 32'd1);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_hold_data", {24'b0, tx_data}, 32'h34);
            check("t4_hold_valid", {31'b0, tx_valid}, 32'd1);
        end
        tx_ready = 1'b1;
        wait_done("t3_done");
        @(negedge clk);
        compare_stream("t3");
        check("t3_addr_count", addr_q.size(), 32'd3);
        if (addr_q.size() == 3) begin
            check("t3_addr0", {27'b0, addr_q[0]}, 32'd30);
            check("t3_addr1", {27'b0, addr_q[1]}, 32'd31);
            check("t3_addr2", {27'b0, addr_q[2]}, 32'd0);
        end

        // Empty block.
        rmode = 0;
`ifdef MEM_TX_CHECKSUM_EN
        run_and_check(7, 0, "t5_empty");
`else
        obs.delete();
        do_start(7, 0);
        check("t5_done_pulse", {31'b0, done}, 32'd1);
        check("t5_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        check("t5_done_low", {31'b0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_bytes", obs.size(), 32'd0);
`endif

        // Start pulsed mid-transfer must be ignored.
        rmode = 1;
        build_exp(5, 4);
        obs.delete();
        do_start(5, 4);
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1; start_addr = 5'd20; word_count = 6'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t5b_done");
        @(negedge clk);
        compare_stream("t5b");

`ifdef MEM_TX_CHECKSUM_EN
        mem[10] = 16'hA55A; mem[11] = 16'h0F0F;
        rmode = 0;
        run_and_check(10, 2, "t6");
        if (obs.size() == 5) check("t6_checksum", {24'b0, obs[4]}, 32'hFF);
`endif

        // Randomized blocks.
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
            rmode = int'($urandom_range(0, 1));
            run_and_check(int'($urandom_range(0, 31)),
                          (it == 3) ? 32 : int'($urandom_range(0, 12)), "rand");
        end

        // Reset while a byte is being presented.
        rmode = 2; tx_ready = 1'b0;
        do_start(0, 2);
        repeat (4) @(posedge clk);
        #1;
        check("t1_valid_before", {31'b0, tx_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_valid_async", {31'b0, tx_valid}, 32'd0);
        check("t1_busy_async", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t1_idle_valid", {31'b0, tx_valid}, 32'd0);
        check("t1_idle_busy", {31'b0, busy}, 32'd0);
        check("t1_idle_addr", {27'b0, read_address}, 32'd0);
        check("t1_idle_data", {24'b0, tx_data}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
